// File: rtl/approx_error_monitor_if.sv
// Sample / control / result bundle for approx_error_monitor.
//   master : drives start, num_samples and one approx/exact sum pair per sample;
//            observes in_ready, busy, done and the accumulated results.
//   slave  : the monitor itself.
interface approx_error_monitor_if #(
    parameter int N     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
);
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     approx_s;
    logic             approx_co;
    logic [N-1:0]     exact_s;
    logic             exact_co;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] error_count;
    logic [CNT_W-1:0] zero_count;
    logic [ACC_W-1:0] sum_ed;
    logic [N:0]       max_ed;

    modport master (
        output start, num_samples, in_valid, approx_s, approx_co, exact_s, exact_co,
        input  in_ready, busy, done, sample_count, error_count, zero_count, sum_ed, max_ed
    );

    modport slave (
        input  start, num_samples, in_valid, approx_s, approx_co, exact_s, exact_co,
        output in_ready, busy, done, sample_count, error_count, zero_count, sum_ed, max_ed
    );
endinterface

// File: rtl/approx_error_monitor.sv
// Error-metric accumulator for an approximate adder checked against its exact
// reference. Each accepted sample yields an error distance
// ED = |{approx_co,approx_s} - {exact_co,exact_s}|; the block accumulates the
// sample count, mismatch count, zero-exact count, saturating ED sum and peak ED.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - approx_error_monitor_if.slave (start/num_samples, sample handshake,
//          busy/done status and result counters)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | accepting samples until num_samples have been taken
// DRAIN | no more accepts; waiting for stage 1 to retire into the totals
// DONE  | results final and held; start begins a new run
module approx_error_monitor #(
    parameter int N     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input logic                   clk,
    input logic                   rst,
    approx_error_monitor_if.slave bus
);
    localparam int ED_W  = N + 1;
    // One bit wider than either operand so the saturation test sees the carry.
    localparam int SUM_W = ((ACC_W > ED_W) ? ACC_W : ED_W) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] accepted_q, accepted_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_err_q, s1_err_d;
    logic             s1_zero_q, s1_zero_d;
    logic [ED_W-1:0]  s1_ed_q, s1_ed_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] error_count_q, error_count_d;
    logic [CNT_W-1:0] zero_count_q, zero_count_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
    logic [ED_W-1:0]  max_ed_q, max_ed_d;

    logic [ED_W-1:0]  approx_v, exact_v, ed;
    logic [SUM_W-1:0] sum_wide;
    logic             in_ready, accept, start_ok;

    assign approx_v = {bus.approx_co, bus.approx_s};
    assign exact_v  = {bus.exact_co, bus.exact_s};
    assign ed       = (approx_v >= exact_v) ? (approx_v - exact_v) : (exact_v - approx_v);
    assign sum_wide = SUM_W'(sum_ed_q) + SUM_W'(s1_ed_q);

    assign in_ready = (state_q == S_RUN) && (accepted_q < num_q);
    assign accept   = in_ready && bus.in_valid;
    assign start_ok = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        accepted_d     = accepted_q;
        s1_valid_d     = accept;
        s1_err_d       = s1_err_q;
        s1_zero_d      = s1_zero_q;
        s1_ed_d        = s1_ed_q;
        sample_count_d = sample_count_q;
        error_count_d  = error_count_q;
        zero_count_d   = zero_count_q;
        sum_ed_d       = sum_ed_q;
        max_ed_d       = max_ed_q;

        if (accept) begin
            s1_ed_d   = ed;
            s1_err_d  = (ed != '0);
            s1_zero_d = (exact_v == '0);
        end

        if (s1_valid_q) begin
            sample_count_d = sample_count_q + CNT_W'(1);
            error_count_d  = error_count_q + CNT_W'(s1_err_q);
            zero_count_d   = zero_count_q + CNT_W'(s1_zero_q);
            sum_ed_d       = (sum_wide > SUM_MAX) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
            if (s1_ed_q > max_ed_q) begin
                max_ed_d = s1_ed_q;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d        = S_RUN;
                    num_d          = bus.num_samples;
                    accepted_d     = '0;
                    s1_valid_d     = 1'b0;
                    sample_count_d = '0;
                    error_count_d  = '0;
                    zero_count_d   = '0;
                    sum_ed_d       = '0;
                    max_ed_d       = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    accepted_d = accepted_q + CNT_W'(1);
                    if (accepted_d == num_q) begin
                        state_d = S_DRAIN;
                    end
                end else if (num_q == '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Stage 1 retires on the edge after the last accept; DONE follows once it reads empty.
                if (!s1_valid_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            num_q          <= '0;
            accepted_q     <= '0;
            s1_valid_q     <= 1'b0;
            s1_err_q       <= 1'b0;
            s1_zero_q      <= 1'b0;
            s1_ed_q        <= '0;
            sample_count_q <= '0;
            error_count_q  <= '0;
            zero_count_q   <= '0;
            sum_ed_q       <= '0;
            max_ed_q       <= '0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            accepted_q     <= accepted_d;
            s1_valid_q     <= s1_valid_d;
            s1_err_q       <= s1_err_d;
            s1_zero_q      <= s1_zero_d;
            s1_ed_q        <= s1_ed_d;
            sample_count_q <= sample_count_d;
            error_count_q  <= error_count_d;
            zero_count_q   <= zero_count_d;
            sum_ed_q       <= sum_ed_d;
            max_ed_q       <= max_ed_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done         = (state_q == S_DONE);
    assign bus.sample_count = sample_count_q;
    assign bus.error_count  = error_count_q;
    assign bus.zero_count   = zero_count_q;
    assign bus.sum_ed       = sum_ed_q;
    assign bus.max_ed       = max_ed_q;
endmodule

// File: tb/tb_approx_error_monitor.sv
module tb_approx_error_monitor;
    localparam int N     = 16;
    localparam int CNT_W = 32;
    localparam int ACC_W = 48;
    localparam int SAT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    approx_error_monitor_if #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) b();
    approx_error_monitor_if #(.N(N), .CNT_W(CNT_W), .ACC_W(SAT_W)) bs();

    approx_error_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .bus(b)
    );
    approx_error_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .bus(bs)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    typedef struct {
        string            name;
        int               num;
        logic [5:0]       vld;
        logic [5:0]       rdy;
        logic [5:0][16:0] a;
        logic [5:0][16:0] e;
        longint           cnt, err, zero, sum, mx;
    } vec_t;

    vec_t vecs[6];

    task automatic set_vec(input int i, input string nm, input int num, input logic [5:0] vld,
                           input logic [5:0] rdy, input longint cnt, input longint err,
                           input longint zero, input longint sum, input longint mx);
        vecs[i].name = nm;  vecs[i].num = num; vecs[i].vld = vld; vecs[i].rdy = rdy;
        vecs[i].a = '0;     vecs[i].e = '0;
        vecs[i].cnt = cnt;  vecs[i].err = err; vecs[i].zero = zero;
        vecs[i].sum = sum;  vecs[i].mx = mx;
    endtask

    task automatic set_smp(input int i, input int k, input logic [16:0] a, input logic [16:0] e);
        vecs[i].a[k] = a;
        vecs[i].e[k] = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [16:0] a, input logic [16:0] e);
        b.in_valid = v;
        {b.approx_co, b.approx_s} = a;
        {b.exact_co, b.exact_s}   = e;
    endtask

    task automatic start_run(input int num);
        b.start = 1'b1;
        b.num_samples = num;
        tick();
        b.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (b.done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) ok = b.done;
    endtask

    task automatic check_results(input string nm, input longint cnt, input longint err,
                                 input longint zero, input longint sum, input longint mx);
        chk($sformatf("%s.sample_count", nm), 64'(b.sample_count), cnt);
        chk($sformatf("%s.error_count", nm),  64'(b.error_count), err);
        chk($sformatf("%s.zero_count", nm),   64'(b.zero_count), zero);
        chk($sformatf("%s.sum_ed", nm),       64'(b.sum_ed), sum);
        chk($sformatf("%s.max_ed", nm),       64'(b.max_ed), mx);
    endtask

    task automatic apply_vec(input int v);
        logic [5:0] rdy_seen;
        bit ok;
        start_run(vecs[v].num);
        rdy_seen = '0;
        for (int k = 0; k < 6; k++) begin
            drive(vecs[v].vld[k], vecs[v].a[k], vecs[v].e[k]);
            rdy_seen[k] = b.in_ready;
            tick();
        end
        b.in_valid = 1'b0;
        chk($sformatf("%s.in_ready_pattern", vecs[v].name), 64'(rdy_seen), 64'(vecs[v].rdy));
        wait_done(10, ok);
        chk($sformatf("%s.done_reached", vecs[v].name), 64'(ok), 64'd1);
        check_results(vecs[v].name, vecs[v].cnt, vecs[v].err, vecs[v].zero,
                      vecs[v].sum, vecs[v].mx);
    endtask

    task automatic gen_pair(output logic [16:0] a, output logic [16:0] e);
        logic [31:0] r1, r2;
        r1 = $urandom();
        r2 = $urandom();
        case ($urandom_range(0, 3))
            0:       begin e = r1[16:0]; a = e; end
            1:       begin e = r1[16:0]; a = e ^ (17'd1 << r2[3:0]); end
            2:       begin e = r1[16:0]; a = r2[16:0]; end
            default: begin e = '0;       a = {9'd0, r2[7:0]}; end
        endcase
    endtask

    // Reference: plain integer arithmetic over the whole sample list.
    task automatic random_run(input int r, input int num, input int gap);
        logic [16:0] sa[$], se[$];
        logic [16:0] ta, te;
        logic [31:0] junk;
        longint m_cnt, m_err, m_zero, m_sum, m_max, ed;
        longint sat_max;
        int idx, cyc, not_ready;
        bit v;
        string nm;
        nm = $sformatf("rnd%0d", r);
        sat_max = (64'sd1 <<< ACC_W) - 1;
        m_cnt = 0; m_err = 0; m_zero = 0; m_sum = 0; m_max = 0;
        for (int i = 0; i < num; i++) begin
            gen_pair(ta, te);
            sa.push_back(ta);
            se.push_back(te);
            ed = (longint'(ta) > longint'(te)) ? longint'(ta) - longint'(te)
                                               : longint'(te) - longint'(ta);
            m_cnt++;
            if (ed != 0) m_err++;
            if (te == 0) m_zero++;
            m_sum = (m_sum + ed > sat_max) ? sat_max : m_sum + ed;
            if (ed > m_max) m_max = ed;
        end

        start_run(num);
        idx = 0; cyc = 0; not_ready = 0;
        while (idx < num && cyc < num * 20 + 20) begin
            v = ($urandom_range(0, 99) >= gap);
            junk = $urandom();
            if (v) drive(1'b1, sa[idx], se[idx]);
            else   drive(1'b0, junk[16:0], junk[31:15]);
            if (!b.in_ready) not_ready++;
            tick();
            if (v) idx++;
            cyc++;
        end
        b.in_valid = 1'b0;
        chk({nm, ".fed_all"}, 64'(idx), 64'(num));
        chk({nm, ".ready_while_owed"}, 64'(not_ready), 64'd0);
        chk({nm, ".ready_after_last"}, 64'(b.in_ready), 64'd0);
        chk({nm, ".done_at_accept+0"}, 64'(b.done), 64'd0);
        tick();
        chk({nm, ".done_at_accept+1"}, 64'(b.done), 64'd0);
        tick();
        chk({nm, ".done_at_accept+2"}, 64'(b.done), 64'd1);
        chk({nm, ".busy_in_done"}, 64'(b.busy), 64'd0);
        check_results(nm, m_cnt, m_err, m_zero, m_sum, m_max);
    endtask

    initial begin
        bit ok;

        b.start = 0;  b.num_samples = '0;  drive(1'b0, '0, '0);
        bs.start = 0; bs.num_samples = '0; bs.in_valid = 0;
        bs.approx_s = '0; bs.approx_co = 0; bs.exact_s = '0; bs.exact_co = 0;

        // stimulus table: bit k of vld/rdy is cycle k after start
        set_vec(0, "equal4", 4, 6'b001111, 6'b001111, 4, 0, 1, 0, 0);
        set_smp(0, 0, 17'h01234, 17'h01234); set_smp(0, 1, 17'h1FFFF, 17'h1FFFF);
        set_smp(0, 2, 17'h00000, 17'h00000); set_smp(0, 3, 17'h08000, 17'h08000);
        set_vec(1, "mixed3", 3, 6'b000111, 6'b000111, 3, 3, 1, 9, 5);
        set_smp(1, 0, 17'h00010, 17'h00013); set_smp(1, 1, 17'h10000, 17'h0FFFF);
        set_smp(1, 2, 17'h00005, 17'h00000);
        set_vec(2, "stall", 2, 6'b011001, 6'b001111, 2, 2, 1, 3, 2);
        set_smp(2, 0, 17'h00001, 17'h00000); set_smp(2, 1, 17'd100, 17'h00000);
        set_smp(2, 2, 17'd100, 17'h00000);   set_smp(2, 3, 17'h00010, 17'h00012);
        set_smp(2, 4, 17'h00050, 17'h00000);
        set_vec(3, "zero_len", 0, 6'b000011, 6'b000000, 0, 0, 0, 0, 0);
        set_smp(3, 0, 17'd5, 17'd0);         set_smp(3, 1, 17'd6, 17'd0);
        set_vec(4, "max_tie", 3, 6'b000111, 6'b000111, 3, 3, 1, 17, 7);
        set_smp(4, 0, 17'h00000, 17'h00007); set_smp(4, 1, 17'h00100, 17'h00107);
        set_smp(4, 2, 17'h00003, 17'h00000);
        set_vec(5, "extreme", 1, 6'b000011, 6'b000001, 1, 1, 1, 64'h1FFFF, 64'h1FFFF);
        set_smp(5, 0, 17'h1FFFF, 17'h00000); set_smp(5, 1, 17'h1FFFE, 17'h00000);

        // reset state
        tick();
        chk("reset.in_ready", 64'(b.in_ready), 0);
        chk("reset.busy", 64'(b.busy), 0);
        chk("reset.done", 64'(b.done), 0);
        check_results("reset", 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) apply_vec(v);

        // zero-length run then restart from DONE
        start_run(0);
        chk("zl.busy", 64'(b.busy), 1);
        tick();
        tick();
        chk("zl.done_within_2", 64'(b.done), 1);
        check_results("zl", 0, 0, 0, 0, 0);
        start_run(1);
        drive(1'b1, 17'd3, 17'd10);
        chk("restart.in_ready", 64'(b.in_ready), 1);
        tick();
        b.in_valid = 1'b0;
        wait_done(10, ok);
        chk("restart.done_reached", 64'(ok), 1);
        check_results("restart", 1, 1, 0, 7, 7);

        for (int r = 0; r < 8; r++)
            random_run(r, $urandom_range(1, 24), $urandom_range(0, 50));

        // reset mid-run
        start_run(10);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 17'(k + 20), 17'd0);
            tick();
        end
        chk("midrst.pre_count", 64'(b.sample_count), 2);
        #3 rst = 1'b1;
        #1;
        chk("midrst.in_ready", 64'(b.in_ready), 0);
        chk("midrst.busy", 64'(b.busy), 0);
        chk("midrst.done", 64'(b.done), 0);
        check_results("midrst", 0, 0, 0, 0, 0);
        b.in_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        chk("midrst.idle_after", 64'(b.busy), 0);
        chk("midrst.no_ready_after", 64'(b.in_ready), 0);

        // saturation on a 4-bit accumulator, with start pulses during RUN and DRAIN
        bs.start = 1'b1; bs.num_samples = 2;
        tick();
        bs.start = 1'b0;
        bs.in_valid = 1'b1; bs.approx_s = 16'd10; bs.exact_s = 16'd0;
        tick();
        bs.start = 1'b1; bs.num_samples = 5;
        bs.approx_s = 16'd20; bs.exact_s = 16'd10;
        tick();
        chk("sat.first_sum", 64'(bs.sum_ed), 10);
        chk("sat.ready_after_2", 64'(bs.in_ready), 0);
        tick();
        bs.start = 1'b0;
        bs.in_valid = 1'b0;
        chk("sat.sum_saturated", 64'(bs.sum_ed), 15);
        tick();
        chk("sat.done", 64'(bs.done), 1);
        tick(); tick(); tick();
        chk("sat.sum_held", 64'(bs.sum_ed), 15);
        chk("sat.error_count", 64'(bs.error_count), 2);
        chk("sat.sample_count", 64'(bs.sample_count), 2);
        chk("sat.max_ed", 64'(bs.max_ed), 10);
        chk("sat.done_held", 64'(bs.done), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
